// File: rtl/rob_nway_pkg.sv
// Shared types for the reorder buffer: per-entry status flags and default geometry.
// The flags are kept apart from the wide data so that status can be reset and the data cannot.
package rob_nway_pkg;

  localparam int ROB_DEPTH     = 32;
  localparam int ROB_WIDTH     = 3;
  localparam int ROB_CDB_LANES = 3;
  localparam int ROB_XLEN      = 32;
  localparam int ROB_RW        = 5;

  typedef struct packed {
    logic busy;
    logic complete;
    logic tkbr;
    logic halt;
  } rob_flags_t;

  localparam rob_flags_t ROB_FLAGS_ALLOC = '{busy: 1'b1, complete: 1'b0, tkbr: 1'b0, halt: 1'b0};

  function automatic logic entry_done(rob_flags_t f);
    return f.busy & f.complete;
  endfunction

endpackage

// File: rtl/rob_nway_retire_sel.sv
// Retire-lane selector: prefix-AND of ready entries from the head, ending the group
// on the first taken branch or halt so that entry retires as the last lane.
module rob_retire_sel
  import rob_nway_pkg::*;
#(
  parameter int W = ROB_WIDTH
) (
  input  logic         enable,
  input  logic [W-1:0] ready,
  input  logic [W-1:0] stop,
  output logic [W-1:0] valid
);

  logic [W-1:0] chain;

  assign chain[0] = enable & ready[0];

  for (genvar gi = 1; gi < W; gi++) begin : g_chain
    assign chain[gi] = chain[gi-1] & ~stop[gi-1] & ready[gi];
  end

  assign valid = chain;

endmodule

// File: rtl/rob_nway.sv
// rob_nway: N-wide reorder buffer with wrap-bit head/tail pointers, CDB completion and in-order retire.
// Build option ROB_CDB_FWD_EN: operand lookup also forwards same-cycle CDB results.
module rob_nway
  import rob_nway_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int W     = ROB_WIDTH,
  parameter int C     = ROB_CDB_LANES,
  parameter int XLEN  = ROB_XLEN,
  parameter int RW    = ROB_RW,
  parameter int TW    = $clog2(DEPTH),
  parameter int CW    = $clog2(W + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                squash,
  input  logic [W-1:0]        dp_valid,
  input  logic [W-1:0]        dp_dest_vld,
  input  logic [W*RW-1:0]     dp_dest_idx,
  output logic [W*TW-1:0]     dp_tag,
  output logic [CW-1:0]       free_cnt,
  input  logic [C-1:0]        cdb_valid,
  input  logic [C*TW-1:0]     cdb_tag,
  input  logic [C*XLEN-1:0]   cdb_value,
  input  logic [C-1:0]        cdb_tkbr,
  input  logic [C-1:0]        cdb_halt,
  input  logic [C*XLEN-1:0]   cdb_npc,
  input  logic [2*W*TW-1:0]   src_tag,
  output logic [2*W-1:0]      src_ready,
  output logic [2*W*XLEN-1:0] src_value,
  output logic [W-1:0]        rt_valid,
  output logic [W*TW-1:0]     rt_tag,
  output logic [W*RW-1:0]     rt_dest_idx,
  output logic [W*XLEN-1:0]   rt_value,
  output logic [W-1:0]        rt_tkbr,
  output logic [W*XLEN-1:0]   rt_npc,
  output logic [W-1:0]        rt_halt,
  output logic                halted
);

  logic [TW:0]     head_reg, tail_reg, count_reg;
  logic            halted_reg;
  rob_flags_t      flags_reg [DEPTH];
  logic [RW-1:0]   dest_reg  [DEPTH];
  logic [XLEN-1:0] value_reg [DEPTH];
  logic [XLEN-1:0] npc_reg   [DEPTH];

  logic [TW+1:0]   space;
  logic [W-1:0]    alloc, rt_ready, rt_stop;
  logic [TW-1:0]   dp_idx  [W];
  logic [TW-1:0]   rt_idx  [W];
  logic [TW-1:0]   cdb_idx [C];
  logic [CW-1:0]   n_alloc, n_ret;

  // Free slots come from the registered count only, so this cycle's retires free space next cycle.
  assign space    = (TW+2)'(DEPTH) - {1'b0, count_reg};
  assign free_cnt = (space >= (TW+2)'(W)) ? CW'(W) : space[CW-1:0];

  for (genvar gi = 0; gi < W; gi++) begin : g_lane
    assign dp_idx[gi]               = tail_reg[TW-1:0] + TW'(gi);
    assign alloc[gi]                = dp_valid[gi] && (CW'(gi) < free_cnt);
    assign dp_tag[gi*TW +: TW]      = dp_idx[gi];
    assign rt_idx[gi]               = head_reg[TW-1:0] + TW'(gi);
    assign rt_ready[gi]             = entry_done(flags_reg[rt_idx[gi]]);
    assign rt_stop[gi]              = flags_reg[rt_idx[gi]].tkbr | flags_reg[rt_idx[gi]].halt;
    assign rt_tag[gi*TW +: TW]      = rt_idx[gi];
    assign rt_dest_idx[gi*RW +: RW] = dest_reg[rt_idx[gi]];
    assign rt_value[gi*XLEN +: XLEN] = value_reg[rt_idx[gi]];
    assign rt_npc[gi*XLEN +: XLEN]  = npc_reg[rt_idx[gi]];
    assign rt_tkbr[gi]              = flags_reg[rt_idx[gi]].tkbr;
    assign rt_halt[gi]              = flags_reg[rt_idx[gi]].halt;
  end

  for (genvar gi = 0; gi < C; gi++) begin : g_cdb
    assign cdb_idx[gi] = cdb_tag[gi*TW +: TW];
  end

  rob_retire_sel #(.W(W)) u_retire_sel (
    .enable (!halted_reg),
    .ready  (rt_ready),
    .stop   (rt_stop),
    .valid  (rt_valid)
  );

  always_comb begin
    n_alloc = '0;
    n_ret   = '0;
    for (int i = 0; i < W; i++) begin
      n_alloc = n_alloc + CW'(alloc[i]);
      n_ret   = n_ret + CW'(rt_valid[i]);
    end
  end

  // Within one edge: completion first, then retire frees, then dispatch claims (disjoint slots).
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) flags_reg[i] <= '0;
    end else begin
      for (int k = 0; k < C; k++) begin
        if (cdb_valid[k] && flags_reg[cdb_idx[k]].busy) begin
          flags_reg[cdb_idx[k]].complete <= 1'b1;
          flags_reg[cdb_idx[k]].tkbr     <= cdb_tkbr[k];
          flags_reg[cdb_idx[k]].halt     <= cdb_halt[k];
        end
      end
      for (int j = 0; j < W; j++) begin
        if (rt_valid[j]) flags_reg[rt_idx[j]] <= '0;
      end
      for (int i = 0; i < W; i++) begin
        if (alloc[i]) flags_reg[dp_idx[i]] <= ROB_FLAGS_ALLOC;
      end
      head_reg  <= head_reg + (TW+1)'(n_ret);
      tail_reg  <= tail_reg + (TW+1)'(n_alloc);
      count_reg <= count_reg + (TW+1)'(n_alloc) - (TW+1)'(n_ret);
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < C; k++) begin
      if (cdb_valid[k] && flags_reg[cdb_idx[k]].busy) begin
        value_reg[cdb_idx[k]] <= cdb_value[k*XLEN +: XLEN];
        npc_reg[cdb_idx[k]]   <= cdb_npc[k*XLEN +: XLEN];
      end
    end
    for (int i = 0; i < W; i++) begin
      if (alloc[i]) dest_reg[dp_idx[i]] <= dp_dest_vld[i] ? dp_dest_idx[i*RW +: RW] : '0;
    end
  end

  // A halt retired alongside a squash still counts: the caller consumes that cycle's retire group.
  always_ff @(posedge clock) begin
    if (reset) halted_reg <= 1'b0;
    else if (|(rt_valid & rt_halt)) halted_reg <= 1'b1;
  end

  assign halted = halted_reg;

  for (genvar gi = 0; gi < 2*W; gi++) begin : g_src
    logic [TW-1:0]   s_idx;
    logic            s_ready;
    logic [XLEN-1:0] s_value;

    assign s_idx = src_tag[gi*TW +: TW];

    always_comb begin
      s_ready = entry_done(flags_reg[s_idx]);
      s_value = value_reg[s_idx];
`ifdef ROB_CDB_FWD_EN
      for (int k = 0; k < C; k++) begin
        if (cdb_valid[k] && (cdb_idx[k] == s_idx) && flags_reg[s_idx].busy) begin
          s_ready = 1'b1;
          s_value = cdb_value[k*XLEN +: XLEN];
        end
      end
`endif
    end

    assign src_ready[gi]               = s_ready;
    assign src_value[gi*XLEN +: XLEN]  = s_value;
  end

endmodule

// File: tb/tb_rob_nway.sv
// Randomized scoreboard bench for rob_nway: a queue-based program-order model predicts
// free slots, retire groups, lookups and halt; a monitor compares each cycle.
module tb_rob_nway;
  localparam int DEPTH = 32, W = 3, C = 3, XLEN = 32, RW = 5;
  localparam int TW = $clog2(DEPTH), CW = $clog2(W + 1);

  logic clock = 1'b0, reset = 1'b1, squash = 1'b0;
  logic [W-1:0]        dp_valid = '0, dp_dest_vld = '0;
  logic [W*RW-1:0]     dp_dest_idx = '0;
  logic [W*TW-1:0]     dp_tag;
  logic [CW-1:0]       free_cnt;
  logic [C-1:0]        cdb_valid = '0, cdb_tkbr = '0, cdb_halt = '0;
  logic [C*TW-1:0]     cdb_tag = '0;
  logic [C*XLEN-1:0]   cdb_value = '0, cdb_npc = '0;
  logic [2*W*TW-1:0]   src_tag = '0;
  logic [2*W-1:0]      src_ready;
  logic [2*W*XLEN-1:0] src_value;
  logic [W-1:0]        rt_valid, rt_tkbr, rt_halt;
  logic [W*TW-1:0]     rt_tag;
  logic [W*RW-1:0]     rt_dest_idx;
  logic [W*XLEN-1:0]   rt_value, rt_npc;
  logic                halted;

  always #5 clock = ~clock;

  rob_nway #(.DEPTH(DEPTH), .W(W), .C(C), .XLEN(XLEN), .RW(RW)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .dp_valid(dp_valid), .dp_dest_vld(dp_dest_vld), .dp_dest_idx(dp_dest_idx),
    .dp_tag(dp_tag), .free_cnt(free_cnt),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_tkbr(cdb_tkbr), .cdb_halt(cdb_halt), .cdb_npc(cdb_npc),
    .src_tag(src_tag), .src_ready(src_ready), .src_value(src_value),
    .rt_valid(rt_valid), .rt_tag(rt_tag), .rt_dest_idx(rt_dest_idx), .rt_value(rt_value),
    .rt_tkbr(rt_tkbr), .rt_npc(rt_npc), .rt_halt(rt_halt), .halted(halted)
  );

  typedef struct { int tag; int dest; } exp_t;
  exp_t exp_q[$];
  int   ord[$];
  bit   m_busy[DEPTH], m_comp[DEPTH], m_tk[DEPTH], m_ht[DEPTH];
  logic [XLEN-1:0] m_val[DEPTH], m_npc[DEPTH];
  int   m_tail = 0;
  bit   m_halted = 1'b0;
  int   tests = 0, fails = 0, n_retired = 0;
  bit   mon_en = 1'b0;

  task automatic check(string name, longint act, longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic int exp_free();
    int s = DEPTH - ord.size();
    return (s < W) ? s : W;
  endfunction

  function automatic int exp_nret();
    int n = 0;
    if (m_halted) return 0;
    for (int j = 0; j < W && j < ord.size(); j++) begin
      if (!m_comp[ord[j]]) break;
      n++;
      if (m_tk[ord[j]] || m_ht[ord[j]]) break;
    end
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_busy[i] = 0; m_comp[i] = 0; m_tk[i] = 0; m_ht[i] = 0;
    end
    ord.delete();
    exp_q.delete();
    m_tail = 0;
  endtask

  // Applies the inputs currently driven to the model, as the DUT does at the next edge.
  task automatic model_step();
    int nret = exp_nret();
    int nfree = exp_free();
    int na = 0;
    if (reset) begin
      model_clear();
      m_halted = 0;
      return;
    end
    for (int j = 0; j < nret; j++) if (m_ht[ord[j]]) m_halted = 1;
    if (squash) begin
      model_clear();
      return;
    end
    for (int k = 0; k < C; k++) begin
      int t = int'(cdb_tag[k*TW +: TW]);
      if (cdb_valid[k] && m_busy[t]) begin
        m_comp[t] = 1;
        m_val[t]  = cdb_value[k*XLEN +: XLEN];
        m_npc[t]  = cdb_npc[k*XLEN +: XLEN];
        m_tk[t]   = cdb_tkbr[k];
        m_ht[t]   = cdb_halt[k];
      end
    end
    for (int j = 0; j < nret; j++) begin
      int t = ord.pop_front();
      m_busy[t] = 0; m_comp[t] = 0;
    end
    for (int i = 0; i < W; i++) begin
      if (dp_valid[i] && i < nfree) begin
        int t = (m_tail + i) % DEPTH;
        int d = dp_dest_vld[i] ? int'(dp_dest_idx[i*RW +: RW]) : 0;
        m_busy[t] = 1; m_comp[t] = 0; m_tk[t] = 0; m_ht[t] = 0;
        ord.push_back(t);
        exp_q.push_back('{tag: t, dest: d});
        na++;
      end
    end
    m_tail = (m_tail + na) % DEPTH;
  endtask

  // Monitor: compares everything the DUT presents against the model, one negedge at a time.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (mon_en) begin
        int en;
        en = exp_nret();
        check("free_cnt", longint'(free_cnt), exp_free());
        check("halted", longint'(halted), m_halted);
        for (int i = 0; i < W; i++)
          check($sformatf("dp_tag[%0d]", i), longint'(dp_tag[i*TW +: TW]), (m_tail + i) % DEPTH);
        for (int j = 0; j < W; j++)
          check($sformatf("rt_valid[%0d]", j), longint'(rt_valid[j]), (j < en) ? 1 : 0);
        for (int j = 0; j < en; j++) begin
          exp_t e;
          if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            break;
          end
          e = exp_q.pop_front();
          n_retired++;
          $display("[TB] retire lane %0d tag %0d dest %0d value %08h", j, rt_tag[j*TW +: TW],
                   rt_dest_idx[j*RW +: RW], rt_value[j*XLEN +: XLEN]);
          check("rt_tag", longint'(rt_tag[j*TW +: TW]), e.tag);
          check("rt_dest_idx", longint'(rt_dest_idx[j*RW +: RW]), e.dest);
          check("rt_value", longint'(rt_value[j*XLEN +: XLEN]), longint'(m_val[e.tag]));
          check("rt_npc", longint'(rt_npc[j*XLEN +: XLEN]), longint'(m_npc[e.tag]));
          check("rt_tkbr", longint'(rt_tkbr[j]), m_tk[e.tag]);
          check("rt_halt", longint'(rt_halt[j]), m_ht[e.tag]);
        end
        for (int s = 0; s < 2*W; s++) begin
          int t;
          bit rdy;
          logic [XLEN-1:0] val;
          t = int'(src_tag[s*TW +: TW]);
          rdy = m_busy[t] && m_comp[t];
          val = m_val[t];
`ifdef ROB_CDB_FWD_EN
          for (int k = 0; k < C; k++)
            if (cdb_valid[k] && int'(cdb_tag[k*TW +: TW]) == t && m_busy[t]) begin
              rdy = 1;
              val = cdb_value[k*XLEN +: XLEN];
            end
`endif
          check($sformatf("src_ready[%0d]", s), longint'(src_ready[s]), rdy);
          if (rdy) check($sformatf("src_value[%0d]", s), longint'(src_value[s*XLEN +: XLEN]), longint'(val));
        end
      end
    end
  end

  task automatic idle();
    squash = 0; dp_valid = '0; dp_dest_vld = '0; dp_dest_idx = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0; cdb_tkbr = '0; cdb_halt = '0; cdb_npc = '0;
    src_tag = '0;
  endtask

  task automatic pick_tag(output int t);
    if (ord.size() > 0 && $urandom_range(3) != 0) t = ord[$urandom_range(ord.size() - 1)];
    else t = $urandom_range(DEPTH - 1);
  endtask

  task automatic drive(int p_disp, int p_cdb, int p_tk, int p_ht, int p_sq);
    int n, t;
    idle();
    n = ($urandom_range(99) < p_disp) ? $urandom_range(W) : 0;
    dp_valid = W'((1 << n) - 1);
    dp_dest_vld = W'($urandom);
    dp_dest_idx = (W*RW)'($urandom);
    for (int k = 0; k < C; k++) begin
      pick_tag(t);
      cdb_valid[k] = ($urandom_range(99) < p_cdb);
      cdb_tag[k*TW +: TW] = TW'(t);
      cdb_value[k*XLEN +: XLEN] = $urandom;
      cdb_npc[k*XLEN +: XLEN] = $urandom;
      cdb_tkbr[k] = ($urandom_range(99) < p_tk);
      cdb_halt[k] = ($urandom_range(99) < p_ht);
    end
    if ($urandom_range(9) == 0) cdb_tag[TW +: TW] = cdb_tag[0 +: TW];
    for (int s = 0; s < 2*W; s++) begin
      pick_tag(t);
      src_tag[s*TW +: TW] = TW'(t);
    end
    squash = ($urandom_range(999) < p_sq);
  endtask

  task automatic finish_cycle();
    #2;
    model_step();
    @(negedge clock);
  endtask

  task automatic run(int cycles, int p_disp, int p_cdb, int p_tk, int p_ht, int p_sq);
    repeat (cycles) begin
      drive(p_disp, p_cdb, p_tk, p_ht, p_sq);
      finish_cycle();
    end
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    finish_cycle();
    reset = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0;
    model_clear();
    m_halted = 0;
    mon_en = 1;
    idle();
    finish_cycle();
    // Directed opening: three dests, out-of-order completion, then the missing tag.
    idle(); dp_valid = 3'b111; dp_dest_vld = 3'b111; dp_dest_idx = {5'd3, 5'd2, 5'd1};
    finish_cycle();
    idle(); cdb_valid = 3'b011; cdb_tag = {5'd0, 5'd0, 5'd2};
    cdb_value = {32'h0, 32'h10, 32'h22};
    finish_cycle();
    idle(); cdb_valid = 3'b001; cdb_tag = {5'd0, 5'd0, 5'd1}; cdb_value = {32'h0, 32'h0, 32'h11};
    finish_cycle();
    idle(); finish_cycle();
    idle(); finish_cycle();
    run(300, 80, 60, 10, 0, 10);
    run(60, 100, 0, 0, 0, 0);
    run(200, 0, 90, 10, 0, 0);
    run(2000, 70, 70, 8, 0, 8);
    run(400, 70, 70, 5, 10, 0);
    do_reset();
    run(200, 70, 70, 8, 0, 5);
    check("retired_any", (n_retired > 0) ? 1 : 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
